// File: rtl/unsign_multiplier.sv
// unsign_multiplier: iterative radix-2 shift-and-add unsigned multiplier
// with a Start/Ready/Busy/Done handshake. Produces a 2W-bit product.
// Optional feature: define UNSIGN_MULTIPLIER_EARLY_EXIT_EN to leave RUN as
// soon as no multiplier bits remain, shortening latency for small operands.
module unsign_multiplier #(
  parameter int unsigned INPUT_BIT_WIDTH = 8
) (
  input  logic                           Clk,
  input  logic                           ResetN,
  input  logic                           Start,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplicand,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplier,
  output logic [2*INPUT_BIT_WIDTH-1:0]   Product,
  output logic                           Ready,
  output logic                           Busy,
  output logic                           Done
);

  localparam int unsigned W  = INPUT_BIT_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);

  // One-hot so each status output is a direct register bit.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t            state;
  logic [2*W-1:0]    acca;
  logic [2*W-1:0]    acc;
  logic [2*W-1:0]    acc_sum;
  logic [W-1:0]      shb;
  logic [W-1:0]      shb_next;
  logic [CW-1:0]     count;
  logic              last;

  // Next partial sum and the RUN exit condition for the current iteration.
  always_comb begin
    acc_sum  = shb[0] ? (acc + acca) : acc;
    shb_next = shb >> 1;
`ifdef UNSIGN_MULTIPLIER_EARLY_EXIT_EN
    last     = (count == CW'(1)) || (shb_next == '0);
`else
    last     = (count == CW'(1));
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      acca    <= '0;
      acc     <= '0;
      shb     <= '0;
      count   <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acca  <= {{W{1'b0}}, Multiplicand};
            shb   <= Multiplier;
            acc   <= '0;
            count <= CW'(W);
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          acca  <= acca << 1;
          shb   <= shb_next;
          count <= count - CW'(1);
          if (last) begin
            // Load from the final sum so Product is valid in the Done cycle.
            Product <= acc_sum;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Ready = state[0];
  assign Busy  = state[1];
  assign Done  = state[2];

endmodule

// File: tb/tb_unsign_multiplier.sv
// Self-checking bench for unsign_multiplier: W=8 and W=16 instances,
// directed corner cases plus randomized operands against a reference model.
module tb_unsign_multiplier;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b1;

  logic        st8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        rdy8, busy8, done8;

  logic        st16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        rdy16, busy16, done16;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  unsign_multiplier #(.INPUT_BIT_WIDTH(8)) dut8 (
    .Clk(Clk), .ResetN(ResetN), .Start(st8),
    .Multiplicand(a8), .Multiplier(b8),
    .Product(p8), .Ready(rdy8), .Busy(busy8), .Done(done8)
  );

  unsign_multiplier #(.INPUT_BIT_WIDTH(16)) dut16 (
    .Clk(Clk), .ResetN(ResetN), .Start(st16),
    .Multiplicand(a16), .Multiplier(b16),
    .Product(p16), .Ready(rdy16), .Busy(busy16), .Done(done16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Number of RUN cycles: W fixed, or MSB position of B (min 1) with early exit.
  function automatic int runlen(input int w, input logic [31:0] b);
    int n;
`ifdef UNSIGN_MULTIPLIER_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < w; i++) if (b[i]) n = i + 1;
`else
    n = w;
`endif
    return n;
  endfunction

  function automatic logic done_w(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic [63:0] prod_w(input int w);
    return (w == 8) ? 64'(p8) : 64'(p16);
  endfunction

  function automatic logic [2:0] status_w(input int w);
    return (w == 8) ? {rdy8, busy8, done8} : {rdy16, busy16, done16};
  endfunction

  // Issue one multiply from an idle negedge; returns at the Ready cycle negedge.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input string tag);
    int n;
    longint unsigned exp;
    exp = longint'(a) * longint'(b);
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
    else        begin a16 = a;     b16 = b;     st16 = 1'b1; end
    @(negedge Clk);
    st8 = 1'b0; st16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 1;
    check({tag, " busy"}, 64'(status_w(w)), 64'(3'b010));
    while (!done_w(w) && n < 60) begin
      @(negedge Clk);
      n++;
    end
    check({tag, " done_cycle"}, 64'(n), 64'(runlen(w, 32'(b)) + 1));
    check({tag, " product"}, prod_w(w), exp);
    @(negedge Clk);
    check({tag, " ready_after"}, 64'(status_w(w)), 64'(3'b100));
    check({tag, " product_hold"}, prod_w(w), exp);
  endtask

  initial begin
    int n, first, second;
    logic [15:0] ra, rb;

    // Asynchronous reset assertion, checked before any clock edge.
    #1 ResetN = 1'b0;
    #1;
    check("reset status8", 64'({rdy8, busy8, done8}), 64'(3'b100));
    check("reset product8", 64'(p8), 64'd0);
    check("reset status16", 64'({rdy16, busy16, done16}), 64'(3'b100));
    check("reset product16", 64'(p16), 64'd0);
    repeat (3) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    check("idle status8", 64'({rdy8, busy8, done8}), 64'(3'b100));

    // Directed corner cases.
    run_op(8, 16'd255, 16'd255, "max8");
    run_op(8, 16'd0,   16'd173, "a_zero");
    run_op(8, 16'd173, 16'd0,   "b_zero");
    run_op(8, 16'd200, 16'd3,   "b_small");
    run_op(8, 16'd1,   16'd1,   "one_one");
    run_op(16, 16'hFFFF, 16'h8001, "w16_corner");

    // Start held high; operands change mid-RUN and must be ignored.
    a8 = 8'd12; b8 = 8'd11; st8 = 1'b1;
    n = 0; first = 0; second = 0;
    while (second == 0 && n < 60) begin
      @(negedge Clk);
      n++;
      if (n == 3) begin
        a8 = 8'd5; b8 = 8'd5;
        check("hold mid_run_busy", 64'({rdy8, busy8, done8}), 64'(3'b010));
      end
      if (done8) begin
        if (first == 0) begin
          first = n;
          check("hold first_product", 64'(p8), 64'd132);
        end else begin
          second = n;
          check("hold second_product", 64'(p8), 64'd25);
        end
      end
    end
    st8 = 1'b0;
    check("hold first_cycle", 64'(first), 64'(runlen(8, 32'd11) + 1));
    check("hold second_cycle", 64'(second), 64'(first + 1 + runlen(8, 32'd5) + 1));
    @(negedge Clk);
    check("hold ready", 64'({rdy8, busy8, done8}), 64'(3'b100));

    // Reset in the middle of a multiply discards it.
    run_op(8, 16'd12, 16'd11, "pre_reset");
    a8 = 8'd7; b8 = 8'd9; st8 = 1'b1;
    @(negedge Clk);
    st8 = 1'b0;
    first = 0;
    repeat (3) begin
      @(negedge Clk);
      if (done8) first = 1;
    end
    check("midrst no_early_done", 64'(first), 64'd0);
    ResetN = 1'b0;
    #1;
    check("midrst product", 64'(p8), 64'd0);
    check("midrst status", 64'({rdy8, busy8, done8}), 64'(3'b100));
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    check("midrst after_release", 64'({rdy8, busy8, done8, p8}), 64'({3'b100, 16'd0}));
    run_op(8, 16'd7, 16'd9, "post_reset");

    // Randomized operands, biased toward short multipliers as well.
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255) >> $urandom_range(0, 7));
      run_op(8, ra, rb, "rand8");
    end
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      run_op(16, ra, rb, "rand16");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
